fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the processor's Moore control FSM. It consumes the control FSM's hab_ri enable and reads the instruction word at the current PC from instruction memory over a req/ack handshake. It latches the word into the instruction register and returns fim_ri so the control FSM can advance from fetch to decode. A bounded wait substitutes a NOP and flags an error, so the control FSM can never hang on a dead memory.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the processor control FSM.
// On hab_ri it reads the word at pc over a req/ack handshake, latches it into
// the instruction register and raises fim_ri until hab_ri drops. A bounded
// wait on mem_ack substitutes NOP_INSTR and flags fetch_err, so the control
// FSM always gets a completion even when memory never answers.
module fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter int                 TIMEOUT   = 15,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hab_ri,
  input  logic [ADDR_W-1:0]  pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               fim_ri,
  output logic               fetch_err,
  output logic [7:0]         fetch_cnt
);

  // Last wait-counter value before the request is abandoned; TIMEOUT is
  // limited to 1..255 so it always fits the 8-bit counter.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q,  addr_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 err_q,   err_d;
  logic [7:0]           cnt_q,   cnt_d;
  logic [7:0]           wait_q,  wait_d;

  // Next-state and datapath update for the fetch handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (hab_ri) begin
          // Accepting a fetch captures pc and clears the previous error.
          state_d = S_REQ;
          addr_d  = pc;
          err_d   = 1'b0;
          wait_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // Ack has priority over the timeout on the final wait cycle.
        if (mem_ack) begin
          instr_d = mem_rdata;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          instr_d = NOP_INSTR;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d  = wait_q + 8'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        // Hold completion until the control FSM releases hab_ri.
        if (hab_ri) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      instr_q <= {INSTR_W{1'b0}};
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Moore outputs decoded from the registered state only, so reset drops
  // mem_req immediately and unused encodings drive both low.
  assign mem_req   = (state_q == S_REQ);
  assign fim_ri    = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[INSTR_W-1 -: 4];
  assign fetch_err = err_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks with randomized fetches checked against a
// transaction-level model (expected instr / count / error per fetch).
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hab_ri = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        fim_ri;
  logic        fetch_err;
  logic [7:0]  fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  logic [15:0] exp_instr = 16'h0000;
  logic [7:0]  exp_cnt   = 8'h00;
  logic        exp_err   = 1'b0;

  fetch_unit #(
    .ADDR_W(8), .INSTR_W(16), .TIMEOUT(TIMEOUT), .NOP_INSTR(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .hab_ri(hab_ri), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .opcode(opcode),
    .fim_ri(fim_ri), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_instr = 16'h0000;
    exp_cnt   = 8'h00;
    exp_err   = 1'b0;
  endtask

  // One full fetch from IDLE. ack_at = REQ cycle (1-based) carrying the ack,
  // 0 = never. drop_early releases hab_ri after the first REQ cycle.
  task automatic do_fetch(input logic [7:0] pc_v, input int ack_at,
                          input logic [15:0] rdata, input bit drop_early,
                          input logic [7:0] pc_during, input bit verbose);
    int  c;
    int  exp_req;
    int  hold;
    bit  acked;
    acked   = (ack_at >= 1) && (ack_at <= TIMEOUT);
    exp_req = acked ? ack_at : TIMEOUT;
    hab_ri  = 1'b1;
    pc      = pc_v;
    mem_ack = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1 || fetch_err !== 1'b0 || fim_ri !== 1'b0) begin
      errors++;
      $display("FAIL req_start: mem_req=%b fetch_err=%b fim_ri=%b, want 1 0 0",
               mem_req, fetch_err, fim_ri);
    end
    c = 0;
    while (mem_req === 1'b1 && c < TIMEOUT + 5) begin
      c++;
      if (mem_addr !== pc_v) begin
        errors++;
        $display("FAIL addr_hold: cycle %0d mem_addr=%h want %h", c, mem_addr, pc_v);
      end
      pc        = pc_during;
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? rdata : 16'($urandom);
      if (drop_early) hab_ri = 1'b0;
      step();
    end
    mem_ack = 1'b0;
    checks++;
    if (c != exp_req) begin
      errors++;
      $display("FAIL req_cycles: mem_req high %0d cycles, want %0d", c, exp_req);
    end
    if (acked) begin
      exp_instr = rdata;
      exp_cnt   = exp_cnt + 8'd1;
      exp_err   = 1'b0;
    end else begin
      exp_instr = 16'h0000;
      exp_err   = 1'b1;
    end
    if (verbose || !acked || ack_at == TIMEOUT) begin
      checks++;
    end else begin
      checks++;
    end
    if (fim_ri !== 1'b1 || instr !== exp_instr || opcode !== exp_instr[15:12] ||
        fetch_err !== exp_err || fetch_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL done: fim=%b instr=%h op=%h err=%b cnt=%0d want 1 %h %h %b %0d",
               fim_ri, instr, opcode, fetch_err, fetch_cnt,
               exp_instr, exp_instr[15:12], exp_err, exp_cnt);
    end
    if (!drop_early) begin
      hold = $urandom_range(0, 2);
      for (int i = 0; i < hold; i++) begin
        step();
        checks++;
        if (fim_ri !== 1'b1 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL done_hold: fim_ri=%b mem_req=%b want 1 0", fim_ri, mem_req);
        end
      end
      hab_ri = 1'b0;
    end
    step();
    checks++;
    if (fim_ri !== 1'b0 || mem_req !== 1'b0 || fetch_err !== exp_err ||
        instr !== exp_instr || fetch_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL back_idle: fim=%b req=%b err=%b instr=%h cnt=%0d want 0 0 %b %h %0d",
               fim_ri, mem_req, fetch_err, instr, fetch_cnt, exp_err, exp_instr, exp_cnt);
    end
  endtask

  task automatic apply_reset();
    hab_ri = 1'b0;
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      pc = 8'($urandom);
      step();
      checks++;
      if (mem_req !== 1'b0 || fim_ri !== 1'b0 || instr !== 16'h0000 ||
          fetch_cnt !== 8'h00 || fetch_err !== 1'b0 || mem_addr !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle: req=%b fim=%b instr=%h cnt=%0d err=%b addr=%h want all 0",
                 mem_req, fim_ri, instr, fetch_cnt, fetch_err, mem_addr);
      end
    end
  endtask

  task automatic test_zero_wait();
    do_fetch(8'h12, 1, 16'hA5C3, 1'b0, 8'h12, 1'b1);
    checks++;
    if (instr !== 16'hA5C3 || opcode !== 4'hA || fetch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL zero_wait: instr=%h opcode=%h cnt=%0d want a5c3 a 1",
               instr, opcode, fetch_cnt);
    end
  endtask

  task automatic test_wait_state();
    do_fetch(8'h12, 4, 16'h1234, 1'b0, 8'h99, 1'b1);
    checks++;
    if (instr !== 16'h1234 || fetch_err !== 1'b0 || mem_addr !== 8'h12) begin
      errors++;
      $display("FAIL wait_state: instr=%h err=%b addr=%h want 1234 0 12",
               instr, fetch_err, mem_addr);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] cnt_before;
    cnt_before = fetch_cnt;
    do_fetch(8'h40, 0, 16'hFFFF, 1'b0, 8'h41, 1'b1);
    checks++;
    if (fetch_err !== 1'b1 || instr !== 16'h0000 || fetch_cnt !== cnt_before) begin
      errors++;
      $display("FAIL timeout: err=%b instr=%h cnt=%0d want 1 0000 %0d",
               fetch_err, instr, fetch_cnt, cnt_before);
    end
    // Next accepted fetch clears the sticky error (checked at REQ start).
    do_fetch(8'h41, 2, 16'h7BCD, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_boundary_ack();
    do_fetch(8'h55, TIMEOUT, 16'hC0DE, 1'b0, 8'hAA, 1'b1);
    checks++;
    if (fetch_err !== 1'b0 || instr !== 16'hC0DE) begin
      errors++;
      $display("FAIL boundary_ack: err=%b instr=%h want 0 c0de", fetch_err, instr);
    end
  endtask

  task automatic test_drop_early();
    do_fetch(8'h21, 3, 16'h3C3C, 1'b1, 8'h22, 1'b1);
    do_fetch(8'h23, 0, 16'h0F0F, 1'b1, 8'h24, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_fetch(8'($urandom), $urandom_range(0, TIMEOUT + 2), 16'($urandom),
               1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      do_fetch(8'(i), 1, 16'(i * 3), 1'b1, 8'(i + 1), 1'b0);
    end
    checks++;
    if (fetch_cnt !== 8'h00) begin
      errors++;
      $display("FAIL cnt_wrap: fetch_cnt=%0d want 0", fetch_cnt);
    end
  endtask

  task automatic test_reset_mid();
    hab_ri = 1'b1;
    pc = 8'h77;
    mem_ack = 1'b0;
    step();
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req: mem_req=%b want 1 in second REQ cycle", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || fim_ri !== 1'b0 || instr !== 16'h0000 || opcode !== 4'h0 ||
        fetch_err !== 1'b0 || fetch_cnt !== 8'h00 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: req=%b fim=%b instr=%h err=%b cnt=%0d addr=%h want all 0",
               mem_req, fim_ri, instr, fetch_err, fetch_cnt, mem_addr);
    end
    hab_ri = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    // Full-length timeout afterwards shows the partial wait was discarded.
    do_fetch(8'h78, 0, 16'h1111, 1'b0, 8'h79, 1'b1);
  endtask

  task automatic test_stray_ack();
    logic [15:0] instr_before;
    logic [7:0]  cnt_before;
    do_fetch(8'h30, 2, 16'h9ABC, 1'b0, 8'h31, 1'b1);
    instr_before = instr;
    cnt_before   = fetch_cnt;
    for (int i = 0; i < 5; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'($urandom);
      step();
      checks++;
      if (instr !== instr_before || fetch_cnt !== cnt_before || fim_ri !== 1'b0 ||
          mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stray_ack: instr=%h cnt=%0d fim=%b req=%b want %h %0d 0 0",
                 instr, fetch_cnt, fim_ri, mem_req, instr_before, cnt_before);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_timeout();
    test_boundary_ack();
    test_drop_early();
    test_stray_ack();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
